// File: rtl/event_scheduler_pkg.sv
// Shared definitions for the event scheduler and the core monitor that watches its bus.
// Message layout: timestamp in the low TIME_WID bits, LP field above it.
package event_scheduler_pkg;

  localparam int DEF_NUM_CORE = 4;
  localparam int DEF_TIME_WID = 16;
  localparam int DEF_MSG_WID  = 32;
  localparam logic [DEF_TIME_WID-1:0] DEF_END_TIME = 16'hFFF0;

  localparam int LP_LSB = DEF_TIME_WID;
  localparam int LP_WID = DEF_MSG_WID - DEF_TIME_WID;

  typedef enum logic [2:0] {
    IDLE,
    DEQ,
    SEND,
    RET,
    DONE
  } sched_state_e;

  function automatic logic [DEF_TIME_WID-1:0] msg_time(input logic [DEF_MSG_WID-1:0] msg);
    return msg[DEF_TIME_WID-1:0];
  endfunction

  function automatic logic [LP_WID-1:0] msg_lp(input logic [DEF_MSG_WID-1:0] msg);
    return msg[LP_LSB +: LP_WID];
  endfunction

endpackage

// File: rtl/event_scheduler_if.sv
// Queue, core and monitor signals shared by the event scheduler (master) and its environment (slave).
interface event_scheduler_if
  import event_scheduler_pkg::*;
#(
  parameter int NUM_CORE = DEF_NUM_CORE,
  parameter int MSG_WID  = DEF_MSG_WID,
  parameter int TIME_WID = DEF_TIME_WID
) ();

  localparam int NB_COREID = $clog2(NUM_CORE);

  logic                         q_vld;
  logic [MSG_WID-1:0]           q_msg;
  logic                         q_deq;
  logic                         q_enq;
  logic [MSG_WID-1:0]           q_enq_msg;
  logic                         q_enq_rdy;
  logic [NUM_CORE-1:0]          core_idle;
  logic [NUM_CORE-1:0]          core_ret_vld;
  logic [NUM_CORE*MSG_WID-1:0]  core_ret_msg;
  logic [NUM_CORE-1:0]          core_ret_ack;
  logic                         disp_vld;
  logic [NB_COREID-1:0]         disp_core_id;
  logic [MSG_WID-1:0]           disp_msg;
  logic                         mon_sent_vld;
  logic                         mon_rcv_vld;
  logic [NUM_CORE-1:0]          core_active;
  logic [TIME_WID-1:0]          min_time;
  logic                         min_time_vld;
  logic                         sim_done;

  modport master (
    input  q_vld, q_msg, q_enq_rdy, core_idle, core_ret_vld, core_ret_msg, min_time, min_time_vld,
    output q_deq, q_enq, q_enq_msg, core_ret_ack, disp_vld, disp_core_id, disp_msg,
           mon_sent_vld, mon_rcv_vld, core_active, sim_done
  );

  modport slave (
    output q_vld, q_msg, q_enq_rdy, core_idle, core_ret_vld, core_ret_msg, min_time, min_time_vld,
    input  q_deq, q_enq, q_enq_msg, core_ret_ack, disp_vld, disp_core_id, disp_msg,
           mon_sent_vld, mon_rcv_vld, core_active, sim_done
  );

endinterface

// File: rtl/event_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer and
// moves the pointer just past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int NB = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic          gnt_vld,
  output logic [N-1:0]  gnt_onehot,
  output logic [NB-1:0] gnt_id
);

  logic [NB-1:0] ptr;
  logic [NB-1:0] idx;

  // N is a power of two, so the index wraps naturally in NB bits
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      idx = ptr + NB'(i);
      if (!gnt_vld && req[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  assign gnt_onehot = gnt_vld ? (N'(1) << gnt_id) : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en && gnt_vld) begin
      ptr <= gnt_id + NB'(1);
    end
  end

endmodule

// File: rtl/event_scheduler.sv
// Sequences the shared queue/monitor bus between event dispatch to idle cores and
// event return from cores, one operation at a time, and tracks which cores hold events.
module event_scheduler
  import event_scheduler_pkg::*;
#(
  parameter int NUM_CORE  = DEF_NUM_CORE,
  parameter int NB_COREID = $clog2(NUM_CORE),
  parameter int TIME_WID  = DEF_TIME_WID,
  parameter int MSG_WID   = DEF_MSG_WID,
  parameter logic [TIME_WID-1:0] END_TIME = DEF_END_TIME
) (
  input  logic              clk,
  input  logic              reset_n,
  event_scheduler_if.master bus
);

  sched_state_e         state;
  logic                 q_deq_r;
  logic                 q_enq_r;
  logic [MSG_WID-1:0]   q_enq_msg_r;
  logic [NUM_CORE-1:0]  ret_ack_r;
  logic                 disp_vld_r;
  logic [NB_COREID-1:0] disp_core_id_r;
  logic [MSG_WID-1:0]   disp_msg_r;
  logic                 sent_vld_r;
  logic                 rcv_vld_r;
  logic [NUM_CORE-1:0]  core_active_r;
  logic                 sim_done_r;
  logic                 last_op_dsp;
  logic [MSG_WID-1:0]   msg_reg;
  logic [NB_COREID-1:0] id_reg;
  logic [NUM_CORE-1:0]  sel_onehot;

  logic                 stop;
  logic                 ret_req;
  logic                 dsp_req;
  logic                 do_ret;
  logic                 do_dsp;
  logic [NUM_CORE-1:0]  dsp_cand;
  logic [MSG_WID-1:0]   ret_sel_msg;

  logic                 dsp_gnt_vld;
  logic [NUM_CORE-1:0]  dsp_gnt_onehot;
  logic [NB_COREID-1:0] dsp_gnt_id;
  logic                 ret_gnt_vld;
  logic [NUM_CORE-1:0]  ret_gnt_onehot;
  logic [NB_COREID-1:0] ret_gnt_id;

  assign stop     = bus.min_time_vld && (bus.min_time >= END_TIME);
  assign dsp_cand = bus.core_idle & ~core_active_r;
  assign ret_req  = (|bus.core_ret_vld) && bus.q_enq_rdy;
  assign dsp_req  = bus.q_vld && (|dsp_cand) && !stop;

  // When both sides want the bus, last_op_dsp decides whose turn it is
  assign do_ret = (state == IDLE) && ret_req && (!dsp_req || last_op_dsp);
  assign do_dsp = (state == IDLE) && dsp_req && !do_ret;

  assign ret_sel_msg = bus.core_ret_msg[int'(ret_gnt_id)*MSG_WID +: MSG_WID];

  rr_arbiter #(.N(NUM_CORE), .NB(NB_COREID)) u_dsp_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (dsp_cand),
    .en         (do_dsp),
    .gnt_vld    (dsp_gnt_vld),
    .gnt_onehot (dsp_gnt_onehot),
    .gnt_id     (dsp_gnt_id)
  );

  rr_arbiter #(.N(NUM_CORE), .NB(NB_COREID)) u_ret_arb (
    .clk        (clk),
    .reset_n    (reset_n),
    .req        (bus.core_ret_vld),
    .en         (do_ret),
    .gnt_vld    (ret_gnt_vld),
    .gnt_onehot (ret_gnt_onehot),
    .gnt_id     (ret_gnt_id)
  );

  // Outputs are registered: each strobe is set on the edge entering its state
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      q_deq_r        <= 1'b0;
      q_enq_r        <= 1'b0;
      q_enq_msg_r    <= '0;
      ret_ack_r      <= '0;
      disp_vld_r     <= 1'b0;
      disp_core_id_r <= '0;
      disp_msg_r     <= '0;
      sent_vld_r     <= 1'b0;
      rcv_vld_r      <= 1'b0;
      core_active_r  <= '0;
      sim_done_r     <= 1'b0;
      last_op_dsp    <= 1'b1;
      msg_reg        <= '0;
      id_reg         <= '0;
      sel_onehot     <= '0;
    end else begin
      q_deq_r    <= 1'b0;
      q_enq_r    <= 1'b0;
      ret_ack_r  <= '0;
      disp_vld_r <= 1'b0;
      sent_vld_r <= 1'b0;
      rcv_vld_r  <= 1'b0;
      case (state)
        IDLE: begin
          if (do_ret && ret_gnt_vld) begin
            state          <= RET;
            q_enq_r        <= 1'b1;
            rcv_vld_r      <= 1'b1;
            ret_ack_r      <= ret_gnt_onehot;
            q_enq_msg_r    <= ret_sel_msg;
            disp_msg_r     <= ret_sel_msg;
            disp_core_id_r <= ret_gnt_id;
            last_op_dsp    <= 1'b0;
          end else if (do_dsp && dsp_gnt_vld) begin
            state       <= DEQ;
            q_deq_r     <= 1'b1;
            msg_reg     <= bus.q_msg;
            id_reg      <= dsp_gnt_id;
            sel_onehot  <= dsp_gnt_onehot;
            last_op_dsp <= 1'b1;
          end else if (stop && (core_active_r == '0)) begin
            state      <= DONE;
            sim_done_r <= 1'b1;
          end
        end
        DEQ: begin
          state          <= SEND;
          disp_vld_r     <= 1'b1;
          sent_vld_r     <= 1'b1;
          disp_core_id_r <= id_reg;
          disp_msg_r     <= msg_reg;
        end
        SEND: begin
          state         <= IDLE;
          core_active_r <= core_active_r | sel_onehot;
        end
        RET: begin
          state         <= IDLE;
          core_active_r <= core_active_r & ~ret_ack_r;
        end
        DONE: begin
          state      <= DONE;
          sim_done_r <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.q_deq        = q_deq_r;
  assign bus.q_enq        = q_enq_r;
  assign bus.q_enq_msg    = q_enq_msg_r;
  assign bus.core_ret_ack = ret_ack_r;
  assign bus.disp_vld     = disp_vld_r;
  assign bus.disp_core_id = disp_core_id_r;
  assign bus.disp_msg     = disp_msg_r;
  assign bus.mon_sent_vld = sent_vld_r;
  assign bus.mon_rcv_vld  = rcv_vld_r;
  assign bus.core_active  = core_active_r;
  assign bus.sim_done     = sim_done_r;

endmodule

// File: tb/tb_event_scheduler.sv
// Randomized bench for event_scheduler: a queue and core environment drives the bus while a
// transaction-level schedule model predicts every strobe, message and active bit per cycle.
`timescale 1ns/1ps
module tb_event_scheduler;
  import event_scheduler_pkg::*;

  localparam int NUM_CORE = 4;
  localparam int MSG_WID  = 32;
  localparam int TIME_WID = 16;
  localparam logic [TIME_WID-1:0] END_TIME = 16'hFFF0;

  typedef struct {
    bit          busy;
    bit          q_deq;
    bit          q_enq;
    bit          disp;
    bit          sent;
    bit          rcv;
    logic [3:0]  ack;
    int          id;
    logic [31:0] msg;
    logic [3:0]  act_set;
    logic [3:0]  act_clr;
  } entry_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  bit   in_reset = 1'b1;
  bit   end_phase = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  event_scheduler_if #(.NUM_CORE(NUM_CORE), .MSG_WID(MSG_WID), .TIME_WID(TIME_WID)) bus ();

  event_scheduler #(
    .NUM_CORE (NUM_CORE),
    .TIME_WID (TIME_WID),
    .MSG_WID  (MSG_WID),
    .END_TIME (END_TIME)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // model state: what the scheduler has committed to, in spec terms
  entry_t      sched[$];
  entry_t      cur;
  int          dsp_ptr, ret_ptr;
  bit          last_dsp;
  logic [3:0]  model_active;
  bit          model_done;

  // environment state
  logic [31:0] evq[$];
  bit          holding[NUM_CORE];
  int          ret_delay[NUM_CORE];
  logic [31:0] held_msg[NUM_CORE];
  logic [3:0]  ret_vld;
  logic [31:0] ret_msg[NUM_CORE];
  bit          saw_deq, saw_disp;
  logic [3:0]  saw_ack;
  int          saw_id;
  logic [31:0] saw_msg;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic entry_t blankEntry();
    entry_t e;
    e.busy = 0; e.q_deq = 0; e.q_enq = 0; e.disp = 0; e.sent = 0; e.rcv = 0;
    e.ack = '0; e.id = 0; e.msg = '0; e.act_set = '0; e.act_clr = '0;
    return e;
  endfunction

  function automatic int rrPick(input logic [3:0] req, input int ptr);
    for (int i = 0; i < NUM_CORE; i++) begin
      if (req[(ptr + i) % NUM_CORE]) return (ptr + i) % NUM_CORE;
    end
    return 0;
  endfunction

  task automatic modelReset();
    sched.delete();
    cur = blankEntry();
    dsp_ptr = 0; ret_ptr = 0; last_dsp = 1;
    model_active = '0; model_done = 0;
  endtask

  // decide the next bus operation from this cycle's inputs, then advance one cycle
  task automatic modelStep();
    logic [3:0] cand;
    bit ret_req, dsp_req, stop_now;
    int k;
    entry_t e;
    if (!model_done && !cur.busy && sched.size() == 0) begin
      stop_now = bus.min_time_vld && (bus.min_time >= END_TIME);
      cand     = bus.core_idle & ~model_active;
      ret_req  = (bus.core_ret_vld != 0) && bus.q_enq_rdy;
      dsp_req  = bus.q_vld && (cand != 0) && !stop_now;
      if (ret_req && (!dsp_req || last_dsp)) begin
        k = rrPick(bus.core_ret_vld, ret_ptr);
        ret_ptr = (k + 1) % NUM_CORE; last_dsp = 0;
        e = blankEntry(); e.busy = 1; e.q_enq = 1; e.rcv = 1; e.id = k;
        e.ack = 4'b0001 << k; e.act_clr = e.ack;
        e.msg = bus.core_ret_msg[k*MSG_WID +: MSG_WID];
        sched.push_back(e);
      end else if (dsp_req) begin
        k = rrPick(cand, dsp_ptr);
        dsp_ptr = (k + 1) % NUM_CORE; last_dsp = 1;
        e = blankEntry(); e.busy = 1; e.q_deq = 1;
        sched.push_back(e);
        e = blankEntry(); e.busy = 1; e.disp = 1; e.sent = 1; e.id = k;
        e.msg = bus.q_msg; e.act_set = 4'b0001 << k;
        sched.push_back(e);
      end else if (stop_now && model_active == '0) begin
        model_done = 1;
      end
    end
    model_active = (model_active | cur.act_set) & ~cur.act_clr;
    if (sched.size() > 0) cur = sched.pop_front();
    else cur = blankEntry();
  endtask

  always @(negedge clk) begin
    if (in_reset) begin
      checkOutput("rst_q_deq", bus.q_deq, 0);
      checkOutput("rst_q_enq", bus.q_enq, 0);
      checkOutput("rst_disp_vld", bus.disp_vld, 0);
      checkOutput("rst_mon_strobes", {bus.mon_sent_vld, bus.mon_rcv_vld}, 0);
      checkOutput("rst_ret_ack", bus.core_ret_ack, 0);
      checkOutput("rst_core_active", bus.core_active, 0);
      checkOutput("rst_sim_done", bus.sim_done, 0);
      modelReset();
      saw_deq = 0; saw_disp = 0; saw_ack = '0;
    end else begin
      checkOutput("q_deq", bus.q_deq, cur.q_deq);
      checkOutput("q_enq", bus.q_enq, cur.q_enq);
      checkOutput("ret_ack", bus.core_ret_ack, cur.ack);
      checkOutput("disp_vld", bus.disp_vld, cur.disp);
      checkOutput("mon_sent_vld", bus.mon_sent_vld, cur.sent);
      checkOutput("mon_rcv_vld", bus.mon_rcv_vld, cur.rcv);
      checkOutput("core_active", bus.core_active, model_active);
      checkOutput("sim_done", bus.sim_done, model_done);
      if (cur.q_enq) checkOutput("q_enq_msg", bus.q_enq_msg, cur.msg);
      if (cur.disp || cur.rcv) begin
        checkOutput("disp_core_id", bus.disp_core_id, 64'(cur.id));
        checkOutput("disp_msg", bus.disp_msg, cur.msg);
      end
      saw_deq  = bus.q_deq;
      saw_ack  = bus.core_ret_ack;
      saw_disp = bus.disp_vld;
      saw_id   = int'(bus.disp_core_id);
      saw_msg  = bus.disp_msg;
      modelStep();
    end
  end

  // react to last cycle's strobes, then randomize the free inputs
  task automatic applyStimulus();
    logic [3:0] busy_mask;
    if (saw_deq && evq.size() > 0) void'(evq.pop_front());
    for (int p = 0; p < NUM_CORE; p++) begin
      if (saw_ack[p]) begin
        evq.push_back(ret_msg[p]);
        ret_vld[p] = 1'b0;
        holding[p] = 0;
      end
    end
    if (saw_disp) begin
      holding[saw_id]   = 1;
      held_msg[saw_id]  = saw_msg;
      ret_delay[saw_id] = $urandom_range(1, 6);
    end
    busy_mask = '0;
    for (int p = 0; p < NUM_CORE; p++) begin
      if (holding[p] && !ret_vld[p]) begin
        if (ret_delay[p] == 0) begin
          ret_vld[p] = 1'b1;
          ret_msg[p] = {held_msg[p][31:16], msg_time(held_msg[p]) + 16'($urandom_range(1, 40))};
        end else begin
          ret_delay[p]--;
        end
      end
      busy_mask[p] = holding[p] || ret_vld[p];
    end
    if ($urandom_range(0, 2) == 0 && evq.size() < 8) evq.push_back($urandom);
    bus.core_idle = 4'($urandom);
    if ($urandom_range(0, 3) != 0) bus.core_idle = bus.core_idle & ~busy_mask;
    bus.q_enq_rdy = ($urandom_range(0, 4) != 0);
    if (end_phase) begin
      bus.min_time_vld = 1'b1;
      bus.min_time     = ($urandom_range(0, 1) == 0) ? END_TIME : 16'hFFFF;
    end else begin
      bus.min_time_vld = ($urandom_range(0, 1) == 0);
      bus.min_time     = ($urandom_range(0, 5) == 0) ? 16'hFFEF : 16'($urandom_range(0, 16'hFFEF));
    end
    bus.q_vld        = (evq.size() > 0);
    bus.q_msg        = (evq.size() > 0) ? evq[0] : '0;
    bus.core_ret_vld = ret_vld;
    for (int p = 0; p < NUM_CORE; p++) bus.core_ret_msg[p*MSG_WID +: MSG_WID] = ret_msg[p];
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    applyStimulus();
  endtask

  initial begin
    bit found;
    ret_vld = '0;
    for (int p = 0; p < NUM_CORE; p++) begin
      holding[p] = 0; ret_delay[p] = 0; held_msg[p] = '0; ret_msg[p] = '0;
    end
    bus.q_vld = 0; bus.q_msg = '0; bus.q_enq_rdy = 1; bus.core_idle = '0;
    bus.core_ret_vld = '0; bus.core_ret_msg = '0; bus.min_time = '0; bus.min_time_vld = 0;
    evq.push_back(32'h0003_0010);
    for (int i = 0; i < 3; i++) evq.push_back($urandom);
    modelReset();

    repeat (3) @(posedge clk);
    #3;
    reset_n  = 1'b1;
    in_reset = 0;

    for (int c = 0; c < 1500; c++) cycle();

    // reset while a dispatch strobe is on the bus
    found = 0;
    for (int c = 0; c < 400 && !found; c++) begin
      cycle();
      @(negedge clk);
      #2;
      if (bus.disp_vld === 1'b1) found = 1;
    end
    checkOutput("send_seen", found, 1);
    reset_n  = 1'b0;
    in_reset = 1;
    #1;
    checkOutput("async_disp_vld", bus.disp_vld, 0);
    checkOutput("async_mon_sent", bus.mon_sent_vld, 0);
    checkOutput("async_core_active", bus.core_active, 0);
    checkOutput("async_q_deq_enq", {bus.q_deq, bus.q_enq}, 0);
    cycle();
    cycle();
    #2;
    reset_n  = 1'b1;
    in_reset = 0;

    for (int c = 0; c < 800; c++) cycle();

    end_phase = 1;
    for (int c = 0; c < 800 && !model_done; c++) cycle();
    checkOutput("done_reached", model_done, 1);
    repeat (10) cycle();
    @(negedge clk);
    #2;
    checkOutput("sim_done_sticky", bus.sim_done, 1);
    checkOutput("done_no_deq", bus.q_deq, 0);

    $display("[TB] finished after %0d checks", checks);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
